// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
package alu_pkg;
    typedef logic [3:0] alu_status_t;

    localparam alu_status_t ST_OK      = 4'b0000;
    localparam alu_status_t ST_INV_ARG = 4'b1000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;
endpackage

// File: rtl/alu_result_stage_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage for ALU sub-ops: 2-entry skid buffer plus error counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int K     = 8,
    parameter int S     = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [K-1:0]     i_cache_result,
    input  logic [S-1:0]     i_cache_status,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [K-1:0]     o_result,
    output logic [S-1:0]     o_status,
    input  logic             i_clr_err,
    output logic [CNT_W-1:0] o_err_cnt
);
    stage_state_t state, state_nxt;
    logic [K-1:0] skid_result;
    logic [S-1:0] skid_status;
    logic [K-1:0] in_result;
    logic         in_err;
    logic         accept, pop;
    logic         load_head, head_from_skid, load_skid;

    // Result is untrusted whenever the sub-op flags an error.
    assign in_err    = (i_cache_status != '0);
    assign in_result = in_err ? '0 : i_cache_result;

    // Handshake decodes only registered state, so o_ready never depends on i_ready.
    assign o_valid = (state != EMPTY);
    assign o_ready = (state != FULL);
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop && !accept) begin
                    state_nxt = EMPTY;
                end else if (accept && pop) begin
                    load_head = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= EMPTY;
            o_result    <= '0;
            o_status    <= '0;
            skid_result <= '0;
            skid_status <= '0;
        end else begin
            state <= state_nxt;
            if (load_head) begin
                o_result <= in_result;
                o_status <= i_cache_status;
            end else if (head_from_skid) begin
                o_result <= skid_result;
                o_status <= skid_status;
            end
            if (load_skid) begin
                skid_result <= in_result;
                skid_status <= i_cache_status;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .inc     (accept & in_err),
        .clr     (i_clr_err),
        .cnt     (o_err_cnt)
    );
endmodule
